md_unit: RTL



---
 rtl/md_unit_pkg.sv | 15 +
 rtl/md_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/md_unit_pkg.sv
// Shared MDop command encodings and multiply/divide unit state type.
// The decoder imports the same MD_* values so both sides agree on MDop.
package md_unit_pkg;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. The result is computed at launch
// and held pending; a down-counter models latency before the architectural commit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [1:0]  MDop,
    input  logic        MDsign,
    input  logic        immWrite,
    input  logic        HIWrite,
    input  logic        HIRead,
    input  logic        kill,
    output logic        busy,
    output logic [31:0] out
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        a_sx, b_sx, b_zero;
    logic [63:0] a64, b64, prod;
    logic [32:0] a33, b33, b33_safe;
    logic [31:0] quo, rem;

    // Sign or zero extension; the low 64 bits of a 64x64 product are exact for both.
    always_comb begin
        a_sx     = MDsign & A[31];
        b_sx     = MDsign & B[31];
        a64      = {{32{a_sx}}, A};
        b64      = {{32{b_sx}}, B};
        prod     = a64 * b64;
        a33      = {a_sx, A};
        b33      = {b_sx, B};
        b_zero   = (B == '0);
        b33_safe = b_zero ? 33'd1 : b33;
        quo      = 32'($signed(a33) / $signed(b33_safe));
        rem      = 32'($signed(a33) % $signed(b33_safe));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    // start takes priority; a concurrent immWrite is dropped
                    if (MDop == MD_MULT) begin
                        state_d   = ST_MUL;
                        cnt_d     = MUL_CNT;
                        pend_hi_d = prod[63:32];
                        pend_lo_d = prod[31:0];
                        pend_wr_d = 1'b1;
                    end else if (MDop == MD_DIV) begin
                        state_d   = ST_DIV;
                        cnt_d     = DIV_CNT;
                        pend_hi_d = rem;
                        pend_lo_d = quo;
                        pend_wr_d = !b_zero;
                    end
                end else if (immWrite && !kill) begin
                    if (HIWrite) hi_d = A;
                    else         lo_d = A;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign out  = HIRead ? hi_q : lo_q;

endmodule
